calc_control_fsm: RTL and testbench
===================================

// Module: calc_control_fsm
// PURPOSE
//  Calculator sequencer sitting directly downstream of the key classifier.
//  Consumes one classified keypress per key_valid strobe, accumulates decimal operands,
//  stores the operator, computes the result on '=' and drives the value/sign/error seen by the display stage.
// PARAMETERS
//  MAX_DIGITS  4    max decimal digits per operand; extra digits ignored
//  OP_W        14   operand width; must hold 10^MAX_DIGITS-1 (9999)
//  RES_W       15   magnitude width for results; = OP_W+1 (holds 19998)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      reset, synchronous, active-high
//  key_valid    in   1      one-cycle strobe: classifier outputs are valid this cycle
//  key_value    in   4      translated key code; digit value when is_number
//  is_number    in   1      key is 0-9
//  is_op        in   1      key is operator
//  is_c         in   1      key is clear
//  is_equ       in   1      key is '='
//  operator     in   2      01 = add (A), 10 = subtract (B); 00/11 never valid
//  display_val  out  RES_W  magnitude to show
//  display_neg  out  1      display_val is negative
//  error        out  1      sticky overflow/illegal-chain flag
//  result_valid out  1      one-cycle pulse when a new result is loaded
//  state_o      out  3      current FSM state (debug/display-mode select)
// BEHAVIOUR
//  Reset: state=ENTER_A; A=B=0; op=00; digit counts=0; all outputs 0.
//  Only cycles with key_valid=1 act; flags ignored otherwise. Priority if several set: C > EQU > OP > NUM.
//  Latency: key on cycle N -> registers/outputs updated at edge ending cycle N; visible cycle N+1.
//  C in any state: same as reset (error cleared). rst also aborts any operation mid-entry.
//  Digit entry: X <= X*10 + key_value while count < MAX_DIGITS, count++; otherwise ignored.
//  key_value > 9 with is_number is ignored.
//  States / transitions:
//   ENTER_A:  NUM -> accumulate A.
//             OP(01/10) -> op latched, OP_WAIT.
//             EQU -> R=A, pulse result_valid, SHOW_RES.
//   OP_WAIT:  NUM -> B=digit, cnt=1, ENTER_B.
//             OP -> replace op.
//             EQU ignored.
//   ENTER_B:  NUM -> accumulate B.
//             EQU -> compute R, SHOW_RES.
//             OP -> compute R; if legal then A=R, B=0, new op, OP_WAIT.
//   SHOW_RES: NUM -> A=digit, cnt=1, ENTER_A.
//             OP -> if R>=0 and R<=10^MAX_DIGITS-1 then A=R, OP_WAIT, else ERROR.
//             EQU ignored.
//   ERROR:    error=1, display 0; only C or rst leaves.
//  Compute: add -> R=A+B, RES_W bits unsigned. Sub -> sign = (B>A), magnitude = |A-B|.
//  Overflow: add result > 10^MAX_DIGITS-1 -> ERROR (checked on EQU and chained OP).
//  display_val: ENTER_A/OP_WAIT show A; ENTER_B shows B; SHOW_RES shows |R| with display_neg=sign;
//  ERROR shows 0. display_neg=0 outside SHOW_RES.
//  op codes 00/11 with is_op are ignored in every state.
// STRUCTURE
//  calc_pkg: state encodings (ENTER_A, OP_WAIT, ENTER_B, SHOW_RES, ERROR), OP_ADD=2'b01, OP_SUB=2'b10.
//  Sub-module calc_operand_acc: x10+digit accumulator with digit counter, load/clear/enable; instantiated for A and B.
//  Top keeps the FSM, the add/sub/compare datapath and the output mux.
// TESTING
//  1,2,A,3,4,= -> display 46, neg=0, result_valid one pulse, state SHOW_RES.
//  5,B,8,= -> display 3, display_neg=1.
//  9,9,9,9,9 -> A=9999 (fifth digit ignored); A,1,= -> ERROR, error=1; C -> all outputs 0, ENTER_A.
//  7,A,B,2,= -> op replaced: display 5. Then A,3,= chains: display 8.
//  2,A,3,A -> A=5, OP_WAIT; 4,= -> 9. rst asserted mid-entry -> all state/outputs reset next cycle.
//  Flags held high with key_valid=0 for 10 cycles -> no state/output change.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: FSM states and operator codes.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    OP_WAIT  = 3'd1,
    ENTER_B  = 3'd2,
    SHOW_RES = 3'd3,
    ERROR    = 3'd4
  } calc_state_t;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  // Only add and subtract are meaningful; 00/11 are dropped at the key interface.
  function automatic logic op_is_legal(input logic [1:0] code);
    return (code == OP_ADD) || (code == OP_SUB);
  endfunction

endpackage

// File: rtl/calc_operand_acc.sv
// Decimal operand accumulator: value <= value*10 + digit while fewer than
// MAX_DIGITS digits have been entered. Clear beats load beats digit entry.
// val_nxt exposes the value the register takes at the next edge so the
// parent can register a display copy in the same cycle.
module calc_operand_acc #(
  parameter int MAX_DIGITS = 4,
  parameter int OP_W       = 14,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [OP_W-1:0]  load_val,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             en,
  input  logic [3:0]       digit,
  output logic [OP_W-1:0]  val,
  output logic [OP_W-1:0]  val_nxt
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next value/count; the count limit keeps val*10+digit within OP_W bits.
  always_comb begin
    val_nxt = val;
    cnt_nxt = cnt;
    if (clr) begin
      val_nxt = '0;
      cnt_nxt = '0;
    end else if (load) begin
      val_nxt = load_val;
      cnt_nxt = load_cnt;
    end else if (en && (cnt < CNT_W'(MAX_DIGITS))) begin
      val_nxt = (val * OP_W'(10)) + OP_W'(digit);
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Operand and digit-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
      cnt <= '0;
    end else begin
      val <= val_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/calc_control_fsm.sv
// Calculator sequencer: consumes classified keypresses, builds operands A/B,
// latches the operator, computes on '=' or a chained operator, and drives the
// registered value/sign/error shown by the display stage.
module calc_control_fsm
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int OP_W       = 14,
  parameter int RES_W      = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_value,
  input  logic             is_number,
  input  logic             is_op,
  input  logic             is_c,
  input  logic             is_equ,
  input  logic [1:0]       operator,
  output logic [RES_W-1:0] display_val,
  output logic             display_neg,
  output logic             error,
  output logic             result_valid,
  output logic [2:0]       state_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [RES_W-1:0] MAX_VAL = RES_W'(10 ** MAX_DIGITS - 1);

  calc_state_t      state, state_n;
  logic [1:0]       op, op_n;
  logic [RES_W-1:0] res_mag, res_mag_n;
  logic             res_neg, res_neg_n;
  logic             pulse_n;
  logic [RES_W-1:0] disp_n;
  logic             dneg_n;

  logic             a_clr, a_load, a_en;
  logic [OP_W-1:0]  a_load_val, a_val, a_nxt;
  logic [CNT_W-1:0] a_load_cnt;
  logic             b_clr, b_load, b_en;
  logic [OP_W-1:0]  b_load_val, b_val, b_nxt;

  logic             digit_ok;
  logic [RES_W-1:0] a_ext, b_ext, sum, diff, calc_mag;
  logic             sub_neg, calc_neg, overflow, chain_ok;

  calc_operand_acc #(.MAX_DIGITS(MAX_DIGITS), .OP_W(OP_W), .CNT_W(CNT_W)) u_acc_a (
    .clk      (clk),
    .rst      (rst),
    .clr      (a_clr),
    .load     (a_load),
    .load_val (a_load_val),
    .load_cnt (a_load_cnt),
    .en       (a_en),
    .digit    (key_value),
    .val      (a_val),
    .val_nxt  (a_nxt)
  );

  calc_operand_acc #(.MAX_DIGITS(MAX_DIGITS), .OP_W(OP_W), .CNT_W(CNT_W)) u_acc_b (
    .clk      (clk),
    .rst      (rst),
    .clr      (b_clr),
    .load     (b_load),
    .load_val (b_load_val),
    .load_cnt (CNT_W'(1)),
    .en       (b_en),
    .digit    (key_value),
    .val      (b_val),
    .val_nxt  (b_nxt)
  );

  // Add/subtract datapath on the current operands and latched operator.
  always_comb begin
    a_ext    = RES_W'(a_val);
    b_ext    = RES_W'(b_val);
    sum      = a_ext + b_ext;
    sub_neg  = (b_val > a_val);
    diff     = sub_neg ? (b_ext - a_ext) : (a_ext - b_ext);
    calc_mag = (op == OP_ADD) ? sum : diff;
    calc_neg = (op == OP_SUB) && sub_neg;
    overflow = (op == OP_ADD) && (sum > MAX_VAL);
    // A chained result must be a valid non-negative operand to become A.
    chain_ok = !overflow && !calc_neg;
    digit_ok = (key_value <= 4'd9);
  end

  // Key decode and next-state logic; one action per key, C > EQU > OP > NUM.
  always_comb begin
    state_n    = state;
    op_n       = op;
    res_mag_n  = res_mag;
    res_neg_n  = res_neg;
    pulse_n    = 1'b0;
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_load_val = '0;
    a_load_cnt = '0;
    a_en       = 1'b0;
    b_clr      = 1'b0;
    b_load     = 1'b0;
    b_load_val = '0;
    b_en       = 1'b0;
    if (key_valid) begin
      if (is_c) begin
        state_n   = ENTER_A;
        op_n      = '0;
        res_mag_n = '0;
        res_neg_n = 1'b0;
        a_clr     = 1'b1;
        b_clr     = 1'b1;
      end else if (is_equ) begin
        case (state)
          ENTER_A: begin
            res_mag_n = a_ext;
            res_neg_n = 1'b0;
            pulse_n   = 1'b1;
            state_n   = SHOW_RES;
          end
          ENTER_B: begin
            if (overflow) begin
              state_n = ERROR;
            end else begin
              res_mag_n = calc_mag;
              res_neg_n = calc_neg;
              pulse_n   = 1'b1;
              state_n   = SHOW_RES;
            end
          end
          default: ;
        endcase
      end else if (is_op) begin
        if (op_is_legal(operator)) begin
          case (state)
            ENTER_A, OP_WAIT: begin
              op_n    = operator;
              state_n = OP_WAIT;
            end
            ENTER_B: begin
              if (chain_ok) begin
                a_load     = 1'b1;
                a_load_val = calc_mag[OP_W-1:0];
                a_load_cnt = CNT_W'(MAX_DIGITS);
                b_clr      = 1'b1;
                op_n       = operator;
                state_n    = OP_WAIT;
              end else begin
                state_n = ERROR;
              end
            end
            SHOW_RES: begin
              if (!res_neg && (res_mag <= MAX_VAL)) begin
                a_load     = 1'b1;
                a_load_val = res_mag[OP_W-1:0];
                a_load_cnt = CNT_W'(MAX_DIGITS);
                b_clr      = 1'b1;
                op_n       = operator;
                state_n    = OP_WAIT;
              end else begin
                state_n = ERROR;
              end
            end
            default: ;
          endcase
        end
      end else if (is_number && digit_ok) begin
        case (state)
          ENTER_A: a_en = 1'b1;
          ENTER_B: b_en = 1'b1;
          OP_WAIT: begin
            b_load     = 1'b1;
            b_load_val = OP_W'(key_value);
            state_n    = ENTER_B;
          end
          SHOW_RES: begin
            a_load     = 1'b1;
            a_load_val = OP_W'(key_value);
            a_load_cnt = CNT_W'(1);
            state_n    = ENTER_A;
          end
          default: ;
        endcase
      end
    end
  end

  // Display source follows the state being entered so outputs stay registered.
  always_comb begin
    disp_n = '0;
    dneg_n = 1'b0;
    case (state_n)
      ENTER_A, OP_WAIT: disp_n = RES_W'(a_nxt);
      ENTER_B:          disp_n = RES_W'(b_nxt);
      SHOW_RES: begin
        disp_n = res_mag_n;
        dneg_n = res_neg_n;
      end
      default: ;
    endcase
  end

  // State, operator, result and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ENTER_A;
      op           <= '0;
      res_mag      <= '0;
      res_neg      <= 1'b0;
      display_val  <= '0;
      display_neg  <= 1'b0;
      error        <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      op           <= op_n;
      res_mag      <= res_mag_n;
      res_neg      <= res_neg_n;
      display_val  <= disp_n;
      display_neg  <= dneg_n;
      error        <= (state_n == ERROR);
      result_valid <= pulse_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_calc_control_fsm.sv
// Scoreboard bench for calc_control_fsm: each key pushes its expected display
// snapshot, which is popped and compared one cycle later.
module tb_calc_control_fsm;

  localparam int K_NUM  = 0;
  localparam int K_OP   = 1;
  localparam int K_EQ   = 2;
  localparam int K_C    = 3;
  localparam int K_IDLE = 4;
  localparam int K_RST  = 5;
  localparam int K_HOLD = 6;
  localparam int K_ALL  = 7;

  localparam int S_A = 0, S_W = 1, S_B = 2, S_R = 3, S_E = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_value = '0;
  logic        is_number = 1'b0;
  logic        is_op = 1'b0;
  logic        is_c = 1'b0;
  logic        is_equ = 1'b0;
  logic [1:0]  operator = '0;
  logic [14:0] display_val;
  logic        display_neg;
  logic        error;
  logic        result_valid;
  logic [2:0]  state_o;

  typedef struct {
    string tag;
    int    disp;
    int    neg;
    int    err;
    int    rv;
    int    st;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  calc_control_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_value    (key_value),
    .is_number    (is_number),
    .is_op        (is_op),
    .is_c         (is_c),
    .is_equ       (is_equ),
    .operator     (operator),
    .display_val  (display_val),
    .display_neg  (display_neg),
    .error        (error),
    .result_valid (result_valid),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".disp"}, int'(display_val), e.disp);
      check({e.tag, ".neg"},  int'(display_neg), e.neg);
      check({e.tag, ".err"},  int'(error), e.err);
      check({e.tag, ".rv"},   int'(result_valid), e.rv);
      check({e.tag, ".st"},   int'(state_o), e.st);
    end
  endtask

  // Called at a falling edge; drives one cycle of stimulus, then compares.
  task automatic key(input int kind, input int v, input string tag,
                     input int d, input int ng, input int er, input int rv, input int st);
    case (kind)
      K_NUM: begin key_valid = 1'b1; is_number = 1'b1; key_value = 4'(v); end
      K_OP:  begin key_valid = 1'b1; is_op = 1'b1; operator = 2'(v); end
      K_EQ:  begin key_valid = 1'b1; is_equ = 1'b1; end
      K_C:   begin key_valid = 1'b1; is_c = 1'b1; end
      K_RST: rst = 1'b1;
      K_HOLD, K_ALL: begin
        key_valid = (kind == K_ALL);
        is_number = 1'b1; is_op = 1'b1; is_c = 1'b1; is_equ = 1'b1;
        key_value = 4'd5; operator = 2'b01;
      end
      default: ;
    endcase
    sb.push_back('{tag, d, ng, er, rv, st});
    @(negedge clk);
    key_valid = 1'b0; is_number = 1'b0; is_op = 1'b0; is_c = 1'b0; is_equ = 1'b0;
    rst = 1'b0;
    compare_out();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    key(K_IDLE, 0, "reset", 0, 0, 0, 0, S_A);

    // 12 + 34 = 46
    key(K_NUM, 1, "s1_d1", 1, 0, 0, 0, S_A);
    key(K_NUM, 2, "s1_d2", 12, 0, 0, 0, S_A);
    key(K_OP, 1, "s1_add", 12, 0, 0, 0, S_W);
    key(K_NUM, 3, "s1_d3", 3, 0, 0, 0, S_B);
    key(K_NUM, 4, "s1_d4", 34, 0, 0, 0, S_B);
    key(K_EQ, 0, "s1_eq", 46, 0, 0, 1, S_R);
    key(K_IDLE, 0, "s1_rv_drop", 46, 0, 0, 0, S_R);

    // 5 - 8 = -3
    key(K_NUM, 5, "s2_d5", 5, 0, 0, 0, S_A);
    key(K_OP, 2, "s2_sub", 5, 0, 0, 0, S_W);
    key(K_NUM, 8, "s2_d8", 8, 0, 0, 0, S_B);
    key(K_EQ, 0, "s2_eq", 3, 1, 0, 1, S_R);

    // 9999 + 1 overflows; error is sticky until C
    key(K_C, 0, "s3_clr", 0, 0, 0, 0, S_A);
    key(K_NUM, 9, "s3_d1", 9, 0, 0, 0, S_A);
    key(K_NUM, 9, "s3_d2", 99, 0, 0, 0, S_A);
    key(K_NUM, 9, "s3_d3", 999, 0, 0, 0, S_A);
    key(K_NUM, 9, "s3_d4", 9999, 0, 0, 0, S_A);
    key(K_NUM, 9, "s3_d5_ignored", 9999, 0, 0, 0, S_A);
    key(K_OP, 1, "s3_add", 9999, 0, 0, 0, S_W);
    key(K_NUM, 1, "s3_b1", 1, 0, 0, 0, S_B);
    key(K_EQ, 0, "s3_ovf", 0, 0, 1, 0, S_E);
    key(K_NUM, 5, "s3_err_num", 0, 0, 1, 0, S_E);
    key(K_EQ, 0, "s3_err_eq", 0, 0, 1, 0, S_E);
    key(K_C, 0, "s3_clr_err", 0, 0, 0, 0, S_A);

    // operator replaced, then chained from result
    key(K_NUM, 7, "s4_d7", 7, 0, 0, 0, S_A);
    key(K_OP, 1, "s4_add", 7, 0, 0, 0, S_W);
    key(K_OP, 2, "s4_sub_repl", 7, 0, 0, 0, S_W);
    key(K_NUM, 2, "s4_d2", 2, 0, 0, 0, S_B);
    key(K_EQ, 0, "s4_eq", 5, 0, 0, 1, S_R);
    key(K_OP, 1, "s4_chain_add", 5, 0, 0, 0, S_W);
    key(K_NUM, 3, "s4_d3", 3, 0, 0, 0, S_B);
    key(K_EQ, 0, "s4_eq2", 8, 0, 0, 1, S_R);

    // chained operator inside ENTER_B
    key(K_C, 0, "s5_clr", 0, 0, 0, 0, S_A);
    key(K_NUM, 2, "s5_d2", 2, 0, 0, 0, S_A);
    key(K_OP, 1, "s5_add", 2, 0, 0, 0, S_W);
    key(K_NUM, 3, "s5_d3", 3, 0, 0, 0, S_B);
    key(K_OP, 1, "s5_chain", 5, 0, 0, 0, S_W);
    key(K_NUM, 4, "s5_d4", 4, 0, 0, 0, S_B);
    key(K_EQ, 0, "s5_eq", 9, 0, 0, 1, S_R);

    // illegal digit and operator codes ignored
    key(K_NUM, 12, "s6_digit12", 9, 0, 0, 0, S_R);
    key(K_C, 0, "s6_clr", 0, 0, 0, 0, S_A);
    key(K_NUM, 6, "s6_d6", 6, 0, 0, 0, S_A);
    key(K_OP, 0, "s6_op00", 6, 0, 0, 0, S_A);
    key(K_OP, 3, "s6_op11", 6, 0, 0, 0, S_A);

    // negative result cannot be chained
    key(K_C, 0, "s7_clr", 0, 0, 0, 0, S_A);
    key(K_NUM, 2, "s7_d2", 2, 0, 0, 0, S_A);
    key(K_OP, 2, "s7_sub", 2, 0, 0, 0, S_W);
    key(K_NUM, 5, "s7_d5", 5, 0, 0, 0, S_B);
    key(K_EQ, 0, "s7_eq", 3, 1, 0, 1, S_R);
    key(K_OP, 1, "s7_neg_chain", 0, 0, 1, 0, S_E);

    // chained overflow in ENTER_B
    key(K_C, 0, "s8_clr", 0, 0, 0, 0, S_A);
    for (int i = 0; i < 4; i++) key(K_NUM, 9, "s8_d9", (i == 0) ? 9 : (i == 1) ? 99 : (i == 2) ? 999 : 9999, 0, 0, 0, S_A);
    key(K_OP, 1, "s8_add", 9999, 0, 0, 0, S_W);
    key(K_NUM, 1, "s8_b1", 1, 0, 0, 0, S_B);
    key(K_OP, 1, "s8_chain_ovf", 0, 0, 1, 0, S_E);

    // '=' in ENTER_A and ignored in OP_WAIT
    key(K_C, 0, "s9_clr", 0, 0, 0, 0, S_A);
    key(K_NUM, 4, "s9_d4", 4, 0, 0, 0, S_A);
    key(K_NUM, 2, "s9_d2", 42, 0, 0, 0, S_A);
    key(K_EQ, 0, "s9_eq_a", 42, 0, 0, 1, S_R);
    key(K_OP, 1, "s9_add", 42, 0, 0, 0, S_W);
    key(K_EQ, 0, "s9_eq_wait", 42, 0, 0, 0, S_W);

    // rst mid-entry
    key(K_NUM, 1, "s10_b1", 1, 0, 0, 0, S_B);
    key(K_RST, 0, "s10_rst", 0, 0, 0, 0, S_A);
    key(K_EQ, 0, "s10_eq_zero", 0, 0, 0, 1, S_R);

    // flags without key_valid do nothing; all flags with key_valid act as C
    key(K_NUM, 3, "s11_d3", 3, 0, 0, 0, S_A);
    for (int i = 0; i < 10; i++) key(K_HOLD, 0, "s11_hold", 3, 0, 0, 0, S_A);
    key(K_ALL, 0, "s11_prio_c", 0, 0, 0, 0, S_A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
